prio_arbiter: RTL

//  - Shares one resource between N requesters, one owner at a time.
//  - Picks a winner from req[N-1:0], registers a one-hot grant plus its binary index, and holds
//    the grant until the owner finishes or a hold timeout expires.
//  - One forced idle cycle between owners for resource turnaround.
//  - Sits in front of the shared priority-encoder datapath and owns the request bus into it.

---
 rtl/prio_arb_pkg.sv | 23 ++
 rtl/prio_arbiter_if.sv | 24 ++
 rtl/prio_pick.sv | 35 +++
 rtl/prio_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared types and defaults for the priority arbiter.
//   state_e : arbiter FSM states (2 bits)
//   N, IDW  : default requester count and index width
//   MAX_HOLD: default maximum grant length in cycles
//   onehot(): binary index -> one-hot grant vector
package prio_arb_pkg;

   localparam int unsigned N        = 8;
   localparam int unsigned IDW      = $clog2(N);
   localparam int unsigned MAX_HOLD = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StRelease = 2'd2
   } state_e;

   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bus between the requesters and the arbiter.
//   req, done                            : driven by requesters (master)
//   gnt, gnt_id, gnt_valid, timeout      : driven by the arbiter (slave)
interface prio_arbiter_if;
   import prio_arb_pkg::*;

   logic [N-1:0]   req;
   logic           done;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   modport master (
      output req, done,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, gnt_valid, timeout
   );

endinterface

// File: rtl/prio_pick.sv
// Combinational rotating-priority picker.
//   req_i    : request vector
//   start_i  : index with the highest priority; priority falls with decreasing index, wrapping
//              from 0 to N-1, so start_i+1 ranks lowest
//   any_o    : at least one request present
//   win_id_o : index of the winning request (0 when none)
module prio_pick
   import prio_arb_pkg::*;
(
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] start_i,
   output logic           any_o,
   output logic [IDW-1:0] win_id_o
);

   int             idx;
   logic [IDW-1:0] idx_l;

   assign any_o = |req_i;

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      win_id_o = '0;
      idx      = 0;
      idx_l    = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx   = (int'(start_i) - k + int'(N)) % int'(N);
         idx_l = IDW'(idx);
         if (req_i[idx_l]) begin
            win_id_o = idx_l;
         end
      end
   end

endmodule

// File: rtl/prio_arbiter.sv
// Single-owner arbiter for a shared resource.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : prio_arbiter_if.slave -- req/done in, registered gnt/gnt_id/gnt_valid/timeout out
// A grant is held until done, owner withdrawal, or MaxHold cycles (timeout pulse). Each grant
// is followed by exactly one cycle with no grant before the next owner is picked.
// Build option: define PRIO_ARBITER_ROUND_ROBIN_EN for rotating priority (last owner ranks
// lowest); otherwise fixed priority with bit N-1 highest.
module prio_arbiter
   import prio_arb_pkg::*;
#(
   parameter int unsigned MaxHold = MAX_HOLD
) (
   input logic            clk,
   input logic            rst,
   prio_arbiter_if.slave  bus
);

   localparam int unsigned HoldW = $clog2(MaxHold);

   state_e             state_q, state_d;
   logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic               timeout_q, timeout_d;

   logic               pick_any;
   logic [IDW-1:0]     pick_id;
   logic [IDW-1:0]     pick_start;
   logic               exit_done, exit_wd, exit_to, exit_any;

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
   logic [IDW-1:0]     last_id_q, last_id_d;

   // Start the search one below the last owner so it ranks lowest.
   assign pick_start = (last_id_q == '0) ? IDW'(N - 1) : last_id_q - 1'b1;
`else
   assign pick_start = IDW'(N - 1);
`endif

   prio_pick u_pick (
      .req_i    (bus.req),
      .start_i  (pick_start),
      .any_o    (pick_any),
      .win_id_o (pick_id)
   );

   assign exit_done = bus.done;
   assign exit_wd   = ~bus.req[gnt_id_q];
   assign exit_to   = (hold_cnt_q == HoldW'(MaxHold - 1));
   assign exit_any  = exit_done | exit_wd | exit_to;

   // Next state. The RELEASE cycle itself never grants; a waiting request is picked on the edge
   // that ends it so successive owners are separated by exactly one empty cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StRelease: state_d = pick_any ? StGrant : StIdle;
         StGrant:           if (exit_any) state_d = StRelease;
         default:           state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      hold_cnt_d  = '0;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
      last_id_d   = last_id_q;
`endif
      unique case (state_q)
         StGrant: begin
            if (exit_any) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               // Timeout is only flagged when the hold limit is the sole reason to leave.
               timeout_d   = exit_to & ~exit_done & ~exit_wd;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
               last_id_d   = gnt_id_q;
`endif
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            if (pick_any) begin
               gnt_d       = onehot(pick_id);
               gnt_id_d    = pick_id;
               gnt_valid_d = 1'b1;
            end else begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
         last_id_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
         last_id_q   <= last_id_d;
`endif
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.timeout   = timeout_q;

endmodule
